// File: rtl/data_mem_stage.sv
// Memory-access stage: answers the core's enabled/completed handshake by
// performing loads and stores on a private, byte-lane organised data RAM.
// READ_LATENCY must lie in 1..4. The RAM is never cleared by reset.

// One byte lane of the data RAM. Each lane has its own write enable.
// The read port is registered, so a read issued at one edge has its data
// available after that edge.
module data_mem_lane #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wbyte,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rbyte
);
  logic [7:0] mem [2**AW];

  // Byte write and registered read; no reset on the storage array
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wbyte;
    if (re) rbyte <= mem[raddr];
  end
endmodule

module data_mem_stage #(
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enabled,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        completed,
  output logic [31:0] rdata,
  output logic        access_err
);
  localparam int NUM_LANES = 4;

  typedef enum logic {IDLE, WAIT} state_t;

  // Everything needed after E0, because the core may change its inputs
  typedef struct packed {
    logic                  is_load;
    logic [2:0]            funct3;
    logic [1:0]            off;
    logic [ADDR_WIDTH-1:0] widx;
    logic [NUM_LANES-1:0]  be;
    logic [31:0]           wdata;
  } req_t;

  state_t state, state_n;
  req_t   req_q, req_n;

  logic        completed_n, access_err_n;
  logic [31:0] rdata_n;

  logic        start, mem_op, bad, is_half, is_word, f3_legal;
  logic [NUM_LANES-1:0] be;
  logic [31:0] wlanes;
  logic        ram_we, ram_re;
  logic [NUM_LANES-1:0][7:0] ram_q;
  logic [31:0] ram_word, load_word;
  logic [READ_LATENCY-1:0] vld_pipe;

  // Address bits above the word index alias onto the same RAM words
  logic unused_addr_hi;
  assign unused_addr_hi = ^{1'b0, addr[31:ADDR_WIDTH+2]};

  assign start = (state == IDLE) && enabled;

  // Decode and classify the incoming request
  always_comb begin
    f3_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
               (funct3 == 3'b100) || (funct3 == 3'b101);
    is_half  = (funct3[1:0] == 2'b01);
    is_word  = (funct3 == 3'b010);
    mem_op   = is_load || is_store;
    // Width/alignment checks only matter when memory is actually touched;
    // an ALU passthrough carries no access to misalign.
    bad = (is_load && is_store) ||
          (mem_op && (!f3_legal ||
                      (is_store && funct3[2]) ||
                      (is_half && addr[0]) ||
                      (is_word && (addr[1:0] != 2'b00))));
  end

  // Byte enables and lane-replicated store data
  always_comb begin
    be     = '1;
    wlanes = wdata;
    case (funct3[1:0])
      2'b00: begin
        be     = 4'b0001 << addr[1:0];
        wlanes = {4{wdata[7:0]}};
      end
      2'b01: begin
        be     = addr[1] ? 4'b1100 : 4'b0011;
        wlanes = {2{wdata[15:0]}};
      end
      default: begin
        be     = '1;
        wlanes = wdata;
      end
    endcase
  end

  // Capture the request at E0
  always_comb begin
    req_n         = req_q;
    if (start) begin
      req_n.is_load = is_load;
      req_n.funct3  = funct3;
      req_n.off     = addr[1:0];
      req_n.widx    = addr[ADDR_WIDTH+1:2];
      req_n.be      = be;
      req_n.wdata   = wlanes;
    end
  end

  // Request register is datapath only; state decides whether it is live
  always_ff @(posedge clk) begin
    req_q <= req_n;
  end

  // The read is issued straight from the live inputs at E0 so the first
  // RAM cycle overlaps acceptance. A store writes at E1, but never while
  // reset is asserted so an aborted store leaves memory untouched.
  assign ram_re = start && is_load && !bad;
  assign ram_we = (state == WAIT) && !req_q.is_load && rstn;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    data_mem_lane #(.AW(ADDR_WIDTH)) u_lane (
      .clk   (clk),
      .we    (ram_we && req_q.be[i]),
      .waddr (req_q.widx),
      .wbyte (req_q.wdata[8*i +: 8]),
      .re    (ram_re),
      .raddr (addr[ADDR_WIDTH+1:2]),
      .rbyte (ram_q[i])
    );
  end

  assign ram_word = ram_q;

  // Extra delay stages so the data lands exactly READ_LATENCY edges after E0
  if (READ_LATENCY == 1) begin : g_lat1
    assign load_word = ram_word;
  end else begin : g_latn
    logic [READ_LATENCY-2:0][31:0] dly;
    // Data delay line behind the RAM output register
    always_ff @(posedge clk) begin
      dly[0] <= ram_word;
      for (int k = 1; k < READ_LATENCY - 1; k++) dly[k] <= dly[k-1];
    end
    assign load_word = dly[READ_LATENCY-2];
  end

  // Valid token travelling alongside the read data; reset kills it
  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= ram_re;
      for (int k = 1; k < READ_LATENCY; k++) vld_pipe[k] <= vld_pipe[k-1];
    end
  end

  // Select and extend the addressed byte/half from the returned word
  function automatic logic [31:0] extract(input logic [31:0] w,
                                          input logic [2:0]  f3,
                                          input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  extract = {{24{b[7]}}, b};
      3'b001:  extract = {{16{h[15]}}, h};
      3'b100:  extract = {24'h0, b};
      3'b101:  extract = {16'h0, h};
      default: extract = w;
    endcase
  endfunction

  // Next-state and registered-output logic
  always_comb begin
    state_n      = state;
    completed_n  = completed;
    rdata_n      = rdata;
    access_err_n = access_err;
    case (state)
      IDLE: begin
        if (enabled) begin
          completed_n  = 1'b0;
          access_err_n = 1'b0;
          if (bad) begin
            access_err_n = 1'b1;
            rdata_n      = '0;
            completed_n  = 1'b1;
          end else if (!mem_op) begin
            rdata_n     = addr;
            completed_n = 1'b1;
          end else begin
            state_n = WAIT;
          end
        end
      end
      WAIT: begin
        // enabled is deliberately not looked at here: no queueing
        if (!req_q.is_load) begin
          completed_n = 1'b1;
          state_n     = IDLE;
        end else if (vld_pipe[READ_LATENCY-1]) begin
          rdata_n     = extract(load_word, req_q.funct3, req_q.off);
          completed_n = 1'b1;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      completed  <= 1'b0;
      rdata      <= '0;
      access_err <= 1'b0;
    end else begin
      state      <= state_n;
      completed  <= completed_n;
      rdata      <= rdata_n;
      access_err <= access_err_n;
    end
  end
endmodule
